// File: rtl/zx_bus_dma.sv
// Z80 bus-master DMA engine: requests the Spectrum bus via BUSREQ/BUSACK and
// moves a block of bytes between an internal FIFO and Z80 memory.
module zx_bus_dma #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 16,
  parameter int DEPTH      = 16,
  parameter int STROBE_CYC = 3
) (
  input  logic              clk_50_clk,
  input  logic              reset_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              bus_req_n,
  input  logic              bus_ack_n,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  output logic              mreq_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  remaining
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam logic [PW:0]   FULL_CNT    = (PW+1)'(DEPTH);
  localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_CYC - 1);

  typedef enum logic [2:0] {IDLE, REQ, SETUP, STROBE, HOLD, RELEASE, FIN} state_t;

  state_t state, state_next;

  logic              ack_s1, ack_s2;
  logic              mode_write;
  logic              abort_pend;
  logic [ADDR_W-1:0] cur_addr, last_addr;
  logic [DATA_W-1:0] data_reg;
  logic [SW-1:0]     strobe_cnt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              full, empty;
  logic              eng_push, eng_pop, push, pop;
  logic              port_push_ok, port_pop_ok;
  logic [DATA_W-1:0] push_data, fifo_head;
  logic              strobe_last, go, abort_now;

  // BUSACK comes straight off the Z80 pins, so it is double-registered first.
  always_ff @(posedge clk_50_clk) begin
    if (reset_reset) begin
      ack_s1 <= 1'b1;
      ack_s2 <= 1'b1;
    end else begin
      ack_s1 <= bus_ack_n;
      ack_s2 <= ack_s1;
    end
  end

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign fifo_head   = mem[rd_ptr];
  assign strobe_last = (strobe_cnt == STROBE_LAST);
  assign go          = mode_write ? !empty : !full;
  assign abort_now   = abort_pend || abort;

  // During a transfer the engine owns one side of the FIFO; the other side stays open.
  assign eng_push     = (state == STROBE) && !mode_write && strobe_last;
  assign eng_pop      = (state == STROBE) && mode_write && strobe_last;
  assign port_push_ok = (state == IDLE) || mode_write;
  assign port_pop_ok  = (state == IDLE) || !mode_write;
  assign in_ready     = !full && port_push_ok;
  assign out_valid    = !empty && port_pop_ok;
  assign out_data     = fifo_head;
  assign push         = eng_push ? !full : (in_valid && in_ready);
  assign pop          = eng_pop ? !empty : (out_valid && out_ready);
  assign push_data    = eng_push ? data_in : in_data;

  always_ff @(posedge clk_50_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_50_clk) begin
    if (reset_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_50_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_next;
  end

  // A SETUP that is still stalled has not started a memory cycle, so abort may leave from there.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = (cmd_len == '0) ? FIN : REQ;
      REQ: begin
        if (abort_now)    state_next = RELEASE;
        else if (!ack_s2) state_next = SETUP;
      end
      SETUP: begin
        if (go)             state_next = STROBE;
        else if (abort_now) state_next = RELEASE;
      end
      STROBE:  if (strobe_last) state_next = HOLD;
      HOLD:    state_next = ((remaining == LEN_W'(1)) || abort_now) ? RELEASE : SETUP;
      RELEASE: state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50_clk) begin
    if (reset_reset) begin
      mode_write <= 1'b0;
      cur_addr   <= '0;
      last_addr  <= '0;
      remaining  <= '0;
      data_reg   <= '0;
      strobe_cnt <= '0;
      abort_pend <= 1'b0;
    end else begin
      if (state == IDLE) abort_pend <= 1'b0;
      else if (abort && (state inside {REQ, SETUP, STROBE, HOLD})) abort_pend <= 1'b1;
      if (state inside {SETUP, STROBE, HOLD}) last_addr <= cur_addr;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            mode_write <= cmd_write;
            cur_addr   <= cmd_addr;
            remaining  <= cmd_len;
          end
        end
        SETUP: begin
          strobe_cnt <= '0;
          if (go && mode_write) data_reg <= fifo_head;
        end
        STROBE: strobe_cnt <= strobe_cnt + 1'b1;
        HOLD: begin
          cur_addr  <= cur_addr + 1'b1;
          remaining <= remaining - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Write data stays latched in data_reg so HOLD keeps it on the pins after the pop.
  always_comb begin
    bus_req_n = 1'b1;
    mreq_n    = 1'b1;
    rd_n      = 1'b1;
    wr_n      = 1'b1;
    data_oe   = 1'b0;
    data_out  = data_reg;
    addr_out  = last_addr;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    aborted   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      REQ: bus_req_n = 1'b0;
      SETUP: begin
        bus_req_n = 1'b0;
        addr_out  = cur_addr;
        if (go) begin
          mreq_n = 1'b0;
          if (mode_write) begin
            data_oe  = 1'b1;
            data_out = fifo_head;
          end
        end
      end
      STROBE: begin
        bus_req_n = 1'b0;
        addr_out  = cur_addr;
        mreq_n    = 1'b0;
        if (mode_write) begin
          wr_n    = 1'b0;
          data_oe = 1'b1;
        end else begin
          rd_n = 1'b0;
        end
      end
      HOLD: begin
        bus_req_n = 1'b0;
        addr_out  = cur_addr;
        data_oe   = mode_write;
      end
      FIN: begin
        done    = 1'b1;
        aborted = abort_pend;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_zx_bus_dma.sv
// Directed bench for zx_bus_dma: a BUSACK responder, a memory model returning
// the address LSB, and a monitor logging every strobe pulse.
module tb_zx_bus_dma;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr, cmd_len;
  logic        abort;
  logic [7:0]  in_data, out_data;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        bus_req_n, bus_ack_n;
  logic [15:0] addr_out;
  logic [7:0]  data_out, data_in;
  logic        data_oe, mreq_n, rd_n, wr_n;
  logic        busy, done, aborted;
  logic [15:0] remaining;

  int tests = 0;
  int fails = 0;

  int          cyc = 0;
  int          wr_cnt, rd_cnt, wr_run, rd_run, req_falls, breq_rise_cyc, done_cyc;
  logic [15:0] wr_addr [16];
  logic [7:0]  wr_data [16];
  int          wr_width [16];
  int          wr_start [16];
  logic [15:0] rd_addr [16];
  int          rd_width [16];
  logic        prev_breq = 1'b1;
  int          req_cnt = 0;

  zx_bus_dma dut (
    .clk_50_clk(clk), .reset_reset(reset_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .bus_req_n(bus_req_n), .bus_ack_n(bus_ack_n), .addr_out(addr_out),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
    .busy(busy), .done(done), .aborted(aborted), .remaining(remaining)
  );

  always #5 clk = ~clk;

  assign data_in = addr_out[7:0];

  // Z80 side: BUSACK falls a few clocks after BUSREQ, rises as soon as it is released.
  initial begin
    bus_ack_n = 1'b1;
    forever begin
      @(negedge clk);
      if (bus_req_n === 1'b0) begin
        req_cnt++;
        if (req_cnt >= 3) bus_ack_n = 1'b0;
      end else begin
        req_cnt   = 0;
        bus_ack_n = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (wr_n === 1'b0) begin
      if (wr_run == 0 && wr_cnt < 16) begin
        wr_addr[wr_cnt]  = addr_out;
        wr_data[wr_cnt]  = data_out;
        wr_start[wr_cnt] = cyc;
      end
      wr_run++;
    end else if (wr_run != 0) begin
      if (wr_cnt < 16) wr_width[wr_cnt] = wr_run;
      wr_cnt++;
      wr_run = 0;
    end
    if (rd_n === 1'b0) begin
      if (rd_run == 0 && rd_cnt < 16) rd_addr[rd_cnt] = addr_out;
      rd_run++;
    end else if (rd_run != 0) begin
      if (rd_cnt < 16) rd_width[rd_cnt] = rd_run;
      rd_cnt++;
      rd_run = 0;
    end
    if (prev_breq === 1'b0 && bus_req_n === 1'b1) breq_rise_cyc = cyc;
    if (prev_breq === 1'b1 && bus_req_n === 1'b0) req_falls++;
    if (done === 1'b1) done_cyc = cyc;
    prev_breq = bus_req_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_cnt = 0; rd_cnt = 0; wr_run = 0; rd_run = 0;
    req_falls = 0; breq_rise_cyc = -1; done_cyc = -100;
  endtask

  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [15:0] len);
    clear_log();
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_byte(input string tag, input logic [7:0] exp);
    checkOutput(tag, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) tick();
    checkOutput($sformatf("%s_done", tag), done, 1);
  endtask

  initial begin
    reset_reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    abort = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    clear_log();
    repeat (3) tick();

    // Reset state
    checkOutput("rst_bus_req_n", bus_req_n, 1);
    checkOutput("rst_strobes", {mreq_n, rd_n, wr_n}, 3'b111);
    checkOutput("rst_data_oe", data_oe, 0);
    checkOutput("rst_addr_out", addr_out, 16'h0000);
    checkOutput("rst_data_out", data_out, 8'h00);
    checkOutput("rst_ready_busy", {cmd_ready, busy}, 2'b10);
    checkOutput("rst_done_aborted", {done, aborted}, 2'b00);
    checkOutput("rst_remaining", remaining, 16'h0000);
    checkOutput("rst_fifo", {out_valid, in_ready}, 2'b01);
    reset_reset = 1'b0;
    tick();

    // Write with preloaded FIFO
    for (int i = 0; i < 4; i++) push_byte(8'hA1 + 8'(i));
    checkOutput("wr_head", out_data, 8'hA1);
    applyStimulus(1'b1, 16'h4000, 16'd4);
    checkOutput("wr_req", {bus_req_n, busy, cmd_ready}, 3'b010);
    checkOutput("wr_rem_start", remaining, 16'd4);
    wait_done("wr", 100);
    checkOutput("wr_aborted", aborted, 0);
    checkOutput("wr_breq_at_done", bus_req_n, 1);
    tick();
    checkOutput("wr_done_gap", done_cyc - breq_rise_cyc, 1);
    checkOutput("wr_done_pulse", done, 0);
    checkOutput("wr_pulses", wr_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wr_addr%0d", i), wr_addr[i], 16'h4000 + 16'(i));
      checkOutput($sformatf("wr_data%0d", i), wr_data[i], 8'hA1 + 8'(i));
      checkOutput($sformatf("wr_width%0d", i), wr_width[i], 3);
    end
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("wr_spacing%0d", i), wr_start[i+1] - wr_start[i], 5);
    checkOutput("wr_fifo_empty", out_valid, 0);
    checkOutput("wr_rem_end", remaining, 16'd0);

    // Read with address wrap
    applyStimulus(1'b0, 16'hFFFE, 16'd3);
    wait_done("rd", 100);
    checkOutput("rd_aborted", aborted, 0);
    tick();
    checkOutput("rd_pulses", rd_cnt, 3);
    checkOutput("rd_addr0", rd_addr[0], 16'hFFFE);
    checkOutput("rd_addr1", rd_addr[1], 16'hFFFF);
    checkOutput("rd_addr2", rd_addr[2], 16'h0000);
    checkOutput("rd_width", rd_width[2], 3);
    checkOutput("rd_no_writes", wr_cnt, 0);
    pop_byte("rd_fifo0", 8'hFE);
    pop_byte("rd_fifo1", 8'hFF);
    pop_byte("rd_fifo2", 8'h00);
    checkOutput("rd_fifo_drained", out_valid, 0);

    // Starvation: only one byte available at first
    push_byte(8'h11);
    applyStimulus(1'b1, 16'h5000, 16'd3);
    repeat (20) tick();
    checkOutput("st_bus_kept", {bus_req_n, busy}, 2'b01);
    checkOutput("st_strobes_high", {mreq_n, wr_n, data_oe}, 3'b110);
    checkOutput("st_one_write", wr_cnt, 1);
    checkOutput("st_remaining", remaining, 16'd2);
    push_byte(8'h22);
    push_byte(8'h33);
    wait_done("st", 100);
    tick();
    checkOutput("st_pulses", wr_cnt, 3);
    checkOutput("st_data1", wr_data[1], 8'h22);
    checkOutput("st_data2", wr_data[2], 8'h33);
    checkOutput("st_addr2", wr_addr[2], 16'h5002);

    // Abort during the third byte's strobe
    for (int i = 0; i < 8; i++) push_byte(8'h80 + 8'(i));
    applyStimulus(1'b1, 16'h6000, 16'd8);
    for (int i = 0; i < 200 && !(wr_n === 1'b0 && wr_cnt == 2); i++) tick();
    checkOutput("ab_reached", {wr_n, 8'(wr_cnt)}, {1'b0, 8'd2});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("ab_strobe_kept", wr_n, 0);
    wait_done("ab", 100);
    checkOutput("ab_aborted", aborted, 1);
    checkOutput("ab_remaining", remaining, 16'd5);
    checkOutput("ab_released", bus_req_n, 1);
    tick();
    checkOutput("ab_pulses", wr_cnt, 3);
    checkOutput("ab_width", wr_width[2], 3);
    checkOutput("ab_fifo_head", out_data, 8'h83);

    // Zero length
    applyStimulus(1'b1, 16'h1234, 16'd0);
    checkOutput("zl_done", {done, aborted, bus_req_n}, 3'b101);
    tick();
    checkOutput("zl_idle", {done, cmd_ready}, 2'b01);
    checkOutput("zl_no_req", req_falls, 0);

    // Reset during a strobe
    applyStimulus(1'b1, 16'h7000, 16'd4);
    for (int i = 0; i < 200 && wr_n !== 1'b0; i++) tick();
    checkOutput("mr_reached", wr_n, 0);
    reset_reset = 1'b1;
    tick();
    checkOutput("mr_strobe", {wr_n, mreq_n, data_oe}, 3'b110);
    checkOutput("mr_bus_req_n", bus_req_n, 1);
    checkOutput("mr_fifo_empty", out_valid, 0);
    checkOutput("mr_idle", {busy, cmd_ready, remaining}, {2'b01, 16'd0});
    reset_reset = 1'b0;
    tick();

    // FIFO stress in IDLE
    for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i));
    checkOutput("fs_full", in_ready, 0);
    push_byte(8'h40);
    checkOutput("fs_still_full", in_ready, 0);
    for (int i = 0; i < 8; i++) pop_byte($sformatf("fs_pop%0d", i), 8'h30 + 8'(i));
    checkOutput("fs_space", in_ready, 1);
    checkOutput("fs_sim_head", out_data, 8'h38);
    in_data   = 8'h50;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) pop_byte($sformatf("fs_tail%0d", i), 8'h39 + 8'(i));
    pop_byte("fs_pushed", 8'h50);
    checkOutput("fs_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zx_bus_dma.md
# zx_bus_dma

Parametrised Z80 bus-master DMA engine for the SD loader subsystem. It takes over the Spectrum bus through the BUSREQ/BUSACK handshake and moves a block of bytes between an internal FIFO and Z80 memory in either direction, one memory cycle per byte, with a programmable strobe width. It sits between the Nios loader's streaming ports and the shared Z80 address, data and control pins, and replaces per-byte software bit-banging of the bus.

## Interface
- ADDR_W, 16: Z80 address width.
- DATA_W, 8: data bus width.
- LEN_W, 16: transfer length counter width.
- DEPTH, 16: FIFO depth in words; a power of two, at least 2.
- STROBE_CYC, 3: clocks that wr_n/rd_n are held low per byte; at least 1.
- clk_50_clk  in  1  system clock; all logic is on the rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  starts a transfer when sampled with cmd_ready high.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = FIFO to memory (write mode); 0 = memory to FIFO (read mode).
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  LEN_W  byte count; 0 completes without touching the bus.
- abort  in  1  stops the transfer after the byte currently in flight.
- in_data / in_valid / in_ready  in / in / out  DATA_W / 1 / 1  push port into the FIFO.
- out_data / out_valid / out_ready  out / out / in  DATA_W / 1 / 1  pop port out of the FIFO; out_data is first-word-fall-through.
- bus_req_n  out  1  Z80 BUSREQ.
- bus_ack_n  in  1  Z80 BUSACK; asynchronous, synchronised internally.
- addr_out  out  ADDR_W  bus address.
- data_out / data_oe / data_in  out / out / in  DATA_W / 1 / DATA_W  data pins split for the tristate at top level.
- mreq_n, rd_n, wr_n  out  1 each  memory control strobes.
- busy  out  1  high whenever the engine is not IDLE.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  qualifies done when the transfer ended early.
- remaining  out  LEN_W  bytes still to transfer.

## Operation
- States: IDLE, REQ, SETUP, STROBE, HOLD, RELEASE, FIN.
- IDLE: on cmd_valid, latch mode, address and length.
  - len = 0: go to FIN.
  - Otherwise drive bus_req_n = 0 and go to REQ.
- REQ: wait until the synchronised bus_ack_n is 0, then go to SETUP. Abort in REQ goes to RELEASE.
- SETUP, write mode: waits while the FIFO is empty. When data is available, drive addr_out, data_out = FIFO head, data_oe = 1 and mreq_n = 0.
- SETUP, read mode: waits while the FIFO is full. When space is available, drive addr_out and mreq_n = 0; data_oe stays 0.
- STROBE: wr_n or rd_n is low for STROBE_CYC clocks.
  - Read mode captures data_in into the FIFO on the last STROBE clock.
  - Write mode pops the FIFO on the last STROBE clock.
- HOLD: strobes and mreq_n go high. In write mode data_oe and data_out are held for this cycle to provide hold time. Address increments modulo 2^ADDR_W (0xFFFF wraps to 0x0000) and remaining decrements.
  - remaining reaches 0, or abort is pending: go to RELEASE.
  - Otherwise: go to SETUP.
- RELEASE: bus_req_n = 1, data_oe = 0, all strobes high; go to FIN the next cycle.
- FIN: done = 1 for one cycle, aborted = 1 if the transfer was aborted; go to IDLE.
- Abort is latched as a sticky flag. It never truncates a strobe. A byte already in SETUP/STROBE/HOLD completes.
- FIFO: independent of mode. Both ports are usable in IDLE, so write data can be preloaded and read data drained after completion. A push and a pop in the same cycle are both accepted when the FIFO is neither empty nor full. A push when full and a pop when empty are ignored. in_ready = not full; out_valid = not empty.
- While the bus is not owned: data_oe = 0, strobes high, addr_out holds its last value.

## Timing
- Reset values: bus_req_n = 1, mreq_n = rd_n = wr_n = 1, data_oe = 0, addr_out = 0, data_out = 0, cmd_ready = 1, busy = 0, done = 0, aborted = 0, remaining = 0, FIFO empty.
- Reset mid-transfer returns every output to its reset value at the next edge, including the bus release and the FIFO flush.
- bus_ack_n passes through a 2-flop synchroniser: REQ exits no earlier than 2 clocks after BUSACK falls.
- Per byte: 1 SETUP + STROBE_CYC STROBE + 1 HOLD = STROBE_CYC + 2 clocks when never stalled (5 clocks at default).
- From the cmd_valid edge to the first mreq_n low: 1 (IDLE) + REQ duration + 0.
- From the last HOLD: bus_req_n rises 1 clock later (RELEASE), and done pulses the clock after that.
- cmd_valid while busy is ignored.

## Test plan
- Write, preloaded: addr 0x4000, len 4, 4 bytes 0xA1..0xA4 preloaded, bus_ack_n low 3 cycles after bus_req_n falls → 4 wr_n pulses of 3 clocks each at 0x4000..0x4003 with matching data; 5 clocks per byte; done pulses with aborted = 0; bus_req_n high before done.
- Read: addr 0xFFFE, len 3, memory model returns address LSB → FIFO holds 0xFE, 0xFF, 0x00 from addresses 0xFFFE, 0xFFFF, 0x0000 (wrap); rd_n low 3 clocks each.
- Starvation: write with len 3, push 1 byte, then delay 10 clocks → engine holds SETUP with strobes high and the bus kept; resumes once data arrives; 3 writes total.
- Abort: len 8, abort asserted during byte 2's STROBE → byte 2 completes, remaining = 5, bus released, done with aborted = 1.
- Zero length, and reset mid-op: len 0 → done 1 clock after the command with the bus never requested; reset_reset asserted during STROBE → next edge has wr_n = 1, bus_req_n = 1, data_oe = 0, FIFO empty.
- FIFO stress in IDLE: DEPTH = 16, 17 pushes → 17th dropped and in_ready = 0; simultaneous push and pop at count 8 → count stays 8.
